skin_bbox_detect: RTL
=====================

Name: skin_bbox_detect

Overview:
- Consumes the registered Y/Cb/Cr pixel stream produced by the RGB-to-YCbCr conversion stage.
- Classifies each active pixel as skin or non-skin by fixed Cb/Cr windows, and outputs a 1-bit mask stream time-aligned with the delayed sync signals.
- Accumulates a per-frame bounding box and pixel count of skin pixels, reported once per frame to the overlay/OSD stage.

Parameters:
- IMG_W, 640, active pixels per line; pixels with x >= IMG_W are ignored.
- IMG_H, 480, active lines per frame; lines with y >= IMG_H are ignored.
- CB_MIN, 77, inclusive lower Cb bound for skin.
- CB_MAX, 127, inclusive upper Cb bound for skin.
- CR_MIN, 133, inclusive lower Cr bound for skin.
- CR_MAX, 173, inclusive upper Cr bound for skin.
- MIN_PIXELS, 64, minimum skin-pixel count for a box to be reported as found.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  synchronous active-low reset.
- i_vs  in  1  vertical sync, active high; rising edge marks frame end.
- i_de  in  1  data enable, high on active pixels.
- i_y  in  8  luma (passed through).
- i_cb  in  8  Cb.
- i_cr  in  8  Cr.
- o_vs  out  1  i_vs delayed 1 cycle.
- o_de  out  1  i_de delayed 1 cycle.
- o_y  out  8  i_y delayed 1 cycle.
- o_mask  out  1  skin flag, aligned with o_de.
- o_box_valid  out  1  one-cycle pulse: box outputs updated.
- o_box_found  out  1  last reported frame had count >= MIN_PIXELS.
- o_x_min  out  11  left edge of last box.
- o_x_max  out  11  right edge of last box.
- o_y_min  out  10  top edge of last box.
- o_y_max  out  10  bottom edge of last box.
- o_pix_cnt  out  20  skin pixels in last frame, saturating.

Behaviour:
- Reset (synchronous, active-low, rst_n; clock clk):
  - All outputs are 0.
  - x_cnt = y_cnt = 0; acc_cnt = 0.
  - acc_xmin = 2047, acc_ymin = 1023, acc_xmax = acc_ymax = 0.
  - frame_armed = 0.
- Position counters:
  - x_cnt increments on each cycle with i_de = 1 and is cleared when i_de = 0.
  - y_cnt increments on each falling edge of i_de (i_de_d = 1, i_de = 0) and is cleared on the rising edge of i_vs.
  - Both counters saturate at their max (2047 / 1023) and never wrap.
- Classification:
  - skin = (CB_MIN <= i_cb <= CB_MAX) && (CR_MIN <= i_cr <= CR_MAX), unsigned compare, bounds inclusive.
  - valid_px = i_de && !i_vs && x_cnt < IMG_W && y_cnt < IMG_H.
- Mask output:
  - o_mask <= valid_px && skin.
  - Latency is exactly 1 cycle; o_vs/o_de/o_y carry the same 1-cycle delay.
  - o_mask = 0 whenever o_de = 0.
- Accumulation, each cycle with valid_px && skin:
  - acc_xmin = min(acc_xmin, x_cnt); acc_xmax = max(acc_xmax, x_cnt).
  - acc_ymin = min(acc_ymin, y_cnt); acc_ymax = max(acc_ymax, y_cnt).
  - acc_cnt += 1, saturating at 2^20-1.
- Frame end (cycle where i_vs = 1 and i_vs_d = 0):
  - If frame_armed = 1:
    - Next cycle o_box_valid = 1 and o_pix_cnt = acc_cnt.
    - If acc_cnt >= MIN_PIXELS: o_box_found = 1 and box outputs take the acc values.
    - Otherwise: o_box_found = 0 and all box outputs = 0.
  - If frame_armed = 0 (first, partial frame after reset): no o_box_valid, outputs unchanged, frame_armed set to 1.
  - In both cases the accumulators reload to their reset values in the same cycle.
- Frame end has priority over accumulation: a pixel on the vs rising-edge cycle is never counted; i_de during i_vs is ignored entirely.
- Box outputs hold until the next o_box_valid.
  - o_box_valid is never high on two consecutive cycles.
  - o_box_valid fires at most once per i_vs rising edge.
- Reset mid-frame discards all partial accumulation and re-arms from scratch: the first vs edge after reset is again suppressed.
- Single skin pixel: min = max on both axes, a legal box of width/height 0.

Test Plan:
- Reset, then two 8x4 frames (IMG_W=8, IMG_H=4, MIN_PIXELS=1), all pixels Cb=100, Cr=150:
  - No o_box_valid at the first vs edge.
  - At the second: o_box_valid pulse, found=1, x 0..7, y 0..3, o_pix_cnt = 32.
- Single skin pixel at (5,2), all other pixels Cb=128 Cr=128:
  - x_min = x_max = 5, y_min = y_max = 2, count = 1.
  - o_mask high for exactly one cycle, 1 cycle after that input pixel.
- Bound edges: Cb=77/127 and Cr=133/173 give mask 1; Cb=76, Cb=128, Cr=132, Cr=174 give mask 0.
- MIN_PIXELS=64 with a frame of 10 skin pixels:
  - o_box_valid=1, found=0, box outputs all 0, o_pix_cnt = 10.
- Line longer than IMG_W (10 pixels with IMG_W=8, all skin):
  - Pixels at x = 8 and 9 give mask 0; x_max = 7.
- Stimulus and sync edge cases:
  - Assert rst_n=0 for 1 cycle mid-frame: all outputs return to 0 and the next vs edge produces no o_box_valid.
  - i_de=1 coincident with the i_vs rising edge: that pixel is not counted.

Source files
------------

// File: rtl/skin_bbox_detect.sv
// skin_bbox_detect: Cb/Cr window skin mask stream plus per-frame skin bounding box
module skin_bbox_detect #(
    parameter int         IMG_W      = 640,
    parameter int         IMG_H      = 480,
    parameter logic [7:0] CB_MIN     = 8'd77,
    parameter logic [7:0] CB_MAX     = 8'd127,
    parameter logic [7:0] CR_MIN     = 8'd133,
    parameter logic [7:0] CR_MAX     = 8'd173,
    parameter int         MIN_PIXELS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_vs,
    input  logic        i_de,
    input  logic [7:0]  i_y,
    input  logic [7:0]  i_cb,
    input  logic [7:0]  i_cr,
    output logic        o_vs,
    output logic        o_de,
    output logic [7:0]  o_y,
    output logic        o_mask,
    output logic        o_box_valid,
    output logic        o_box_found,
    output logic [10:0] o_x_min,
    output logic [10:0] o_x_max,
    output logic [9:0]  o_y_min,
    output logic [9:0]  o_y_max,
    output logic [19:0] o_pix_cnt
);
    localparam logic [10:0] LP_W   = 11'(IMG_W);
    localparam logic [9:0]  LP_H   = 10'(IMG_H);
    localparam logic [19:0] LP_MIN = 20'(MIN_PIXELS);

    logic [10:0] r_x, r_xmin, r_xmax;
    logic [9:0]  r_y, r_ymin, r_ymax;
    logic [19:0] r_cnt;
    logic        r_armed;
    logic        w_rise, w_fall, w_skin, w_hit, w_found;

    // o_vs / o_de are the one-cycle delayed syncs, reused for edge detection
    assign w_rise  = i_vs & ~o_vs;
    assign w_fall  = o_de & ~i_de;
    assign w_skin  = (i_cb >= CB_MIN) && (i_cb <= CB_MAX) && (i_cr >= CR_MIN) && (i_cr <= CR_MAX);
    assign w_hit   = i_de && !i_vs && (r_x < LP_W) && (r_y < LP_H) && w_skin;
    assign w_found = r_cnt >= LP_MIN;

    // saturating pixel / line position counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            r_x <= !i_de ? '0 : (&r_x) ? r_x : r_x + 11'd1;
            r_y <= w_rise ? '0 : (w_fall && !(&r_y)) ? r_y + 10'd1 : r_y;
        end
    end

    // one-cycle video pipeline carrying the skin mask
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_vs   <= 1'b0;
            o_de   <= 1'b0;
            o_y    <= '0;
            o_mask <= 1'b0;
        end else begin
            o_vs   <= i_vs;
            o_de   <= i_de;
            o_y    <= i_y;
            o_mask <= w_hit;
        end
    end

    // box accumulation; frame end reports (when armed) and reloads, taking priority over pixels
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_xmin      <= '1;
            r_xmax      <= '0;
            r_ymin      <= '1;
            r_ymax      <= '0;
            r_cnt       <= '0;
            r_armed     <= 1'b0;
            o_box_valid <= 1'b0;
            o_box_found <= 1'b0;
            o_x_min     <= '0;
            o_x_max     <= '0;
            o_y_min     <= '0;
            o_y_max     <= '0;
            o_pix_cnt   <= '0;
        end else begin
            o_box_valid <= 1'b0;
            if (w_rise) begin
                r_armed <= 1'b1;
                r_xmin  <= '1;
                r_xmax  <= '0;
                r_ymin  <= '1;
                r_ymax  <= '0;
                r_cnt   <= '0;
                if (r_armed) begin
                    o_box_valid <= 1'b1;
                    o_pix_cnt   <= r_cnt;
                    o_box_found <= w_found;
                    o_x_min     <= w_found ? r_xmin : '0;
                    o_x_max     <= w_found ? r_xmax : '0;
                    o_y_min     <= w_found ? r_ymin : '0;
                    o_y_max     <= w_found ? r_ymax : '0;
                end
            end else if (w_hit) begin
                if (r_x < r_xmin) r_xmin <= r_x;
                if (r_x > r_xmax) r_xmax <= r_x;
                if (r_y < r_ymin) r_ymin <= r_y;
                if (r_y > r_ymax) r_ymax <= r_y;
                if (!(&r_cnt)) r_cnt <= r_cnt + 20'd1;
            end
        end
    end
endmodule
